// File: rtl/sp_ram_arbiter_if.sv
// sp_ram_arbiter_if: requester and RAM-side signals shared by the arbiter and its clients
interface sp_ram_arbiter_if #(
    parameter int ABITS = 4,
    parameter int WIDTH = 8
);
    logic             req0, we0, gnt0, rvalid0;
    logic [ABITS-1:0] addr0;
    logic [WIDTH-1:0] wdata0, rdata0;
    logic             req1, we1, gnt1, rvalid1;
    logic [ABITS-1:0] addr1;
    logic [WIDTH-1:0] wdata1, rdata1;
    logic             ram_wren, ram_rden;
    logic [ABITS-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output ram_wren, ram_rden, ram_addr, ram_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  ram_wren, ram_rden, ram_addr, ram_wdata
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-requester arbiter for one single-port read-first RAM.
// Default: round-robin with a MAX_BURST fairness limit.
// Define SP_RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module sp_ram_arbiter #(
    parameter int ABITS     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst_n,
    sp_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB_IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] MB = 4'(MAX_BURST);

    state_t           state_q, state_d;
    logic [3:0]       burst_q, burst_d;
    logic             last_q, last_d;
    logic             rd_pend_q, rd_pend_d, rd_who_q, rd_who_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic             g0, g1, rv0, rv1;

    // Grant decision, burst accounting and next arbitration state
    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        burst_d = burst_q;
        last_d  = last_q;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        g0 = bus.req0;
        g1 = bus.req1 & ~bus.req0;
`else
        case (state_q)
            OWN0: begin
                g0 = bus.req0 & ~(bus.req1 & (burst_q >= MB));
                g1 = bus.req1 & ~g0;
            end
            OWN1: begin
                g1 = bus.req1 & ~(bus.req0 & (burst_q >= MB));
                g0 = bus.req0 & ~g1;
            end
            default: begin
                g0 = bus.req0 & (~bus.req1 | last_q);
                g1 = bus.req1 & ~g0;
            end
        endcase
        // A new owner starts its count at this grant; the count only advances under contention
        if (g0)
            burst_d = (state_q != OWN0) ? {3'b000, bus.req1} :
                      (bus.req1 && burst_q < MB) ? burst_q + 4'd1 : burst_q;
        else if (g1)
            burst_d = (state_q != OWN1) ? {3'b000, bus.req0} :
                      (bus.req0 && burst_q < MB) ? burst_q + 4'd1 : burst_q;
        else
            burst_d = 4'd0;
        last_d = (g0 | g1) ? g1 : last_q;
`endif
        state_d = g0 ? OWN0 : g1 ? OWN1 : ARB_IDLE;
    end

    // RAM drive, read tag capture and read-data return
    always_comb begin
        addr_d    = g0 ? bus.addr0 : g1 ? bus.addr1 : addr_q;
        wdata_d   = g0 ? bus.wdata0 : g1 ? bus.wdata1 : wdata_q;
        rd_pend_d = (g0 & ~bus.we0) | (g1 & ~bus.we1);
        rd_who_d  = g1;
        rv0       = rd_pend_q & ~rd_who_q;
        rv1       = rd_pend_q & rd_who_q;
        rdata0_d  = rv0 ? bus.ram_rdata : rdata0_q;
        rdata1_d  = rv1 ? bus.ram_rdata : rdata1_q;
    end

    assign bus.gnt0      = g0;
    assign bus.gnt1      = g1;
    assign bus.ram_wren  = (g0 & bus.we0) | (g1 & bus.we1);
    assign bus.ram_rden  = rd_pend_d;
    assign bus.ram_addr  = addr_d;
    assign bus.ram_wdata = wdata_d;
    assign bus.rvalid0   = rv0;
    assign bus.rvalid1   = rv1;
    assign bus.rdata0    = rdata0_d;
    assign bus.rdata1    = rdata1_d;

    // State registers; reset drops any read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            burst_q   <= 4'd0;
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_who_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_who_q  <= rd_who_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end
endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Two-requester arbiter that shares one single-port, read-first synchronous RAM (ABITS address bits, WIDTH data bits) between requester 0 and requester 1.
- Each cycle it grants at most one request and drives the RAM's wren/rden/addr/wdata.
- It returns read data to the granted requester with a valid strobe one cycle later.
- It sits between two client engines and one shared memory macro.

Parameters:
ABITS, 4, RAM address width
WIDTH, 8, RAM data width
MAX_BURST, 4, max consecutive grants to one requester while the other is waiting (range 1..15)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request valid
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ABITS  requester 0 address
wdata0  in  WIDTH  requester 0 write data
gnt0  out  1  requester 0 accepted this cycle (combinational)
rvalid0  out  1  requester 0 read data valid
rdata0  out  WIDTH  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
ram_wren  out  1  RAM write enable
ram_rden  out  1  RAM read enable
ram_addr  out  ABITS  RAM address
ram_wdata  out  WIDTH  RAM write data
ram_rdata  in  WIDTH  RAM read data, registered, valid the cycle after ram_rden

Behaviour:
- Handshake:
  - A request is accepted when req and gnt are both high in the same cycle.
  - The requester holds req, we, addr and wdata stable until accepted.
  - gnt is a combinational function of req0, req1 and registered state.
  - gnt0 and gnt1 are never high together.
- RAM drive:
  - The granted requester's addr/wdata pass straight to ram_addr/ram_wdata.
  - ram_wren = gnt & we; ram_rden = gnt & ~we.
  - With no grant, wren = rden = 0; addr and wdata hold their last driven values (registered mux select).
- Arbitration: states ARB_IDLE, OWN0, OWN1.
  - ARB_IDLE + req0 only -> grant 0, go to OWN0. req1 only -> grant 1, go to OWN1.
  - ARB_IDLE + both requesting -> grant the requester opposite to last_owner (reset value of last_owner = 1, so 0 wins first).
  - OWNx: keep granting x while reqx is high and burst_cnt < MAX_BURST.
  - burst_cnt increments per grant to x while the other requester is waiting; it resets to 0 on an owner change.
  - When burst_cnt reaches MAX_BURST and the other requester is waiting -> grant the other, switch state, clear burst_cnt.
  - OWNx with reqx low: grant the other if requesting, else go to ARB_IDLE.
  - last_owner updates on every grant.
- Read return:
  - A registered tag (rd_pend, rd_who) is captured on each accepted read.
  - Next cycle, rvalid of that requester = 1 and its rdata = ram_rdata.
  - rdata of the non-target requester holds its previous value.
  - Read latency is exactly 1 cycle after acceptance; back-to-back reads give one rvalid per cycle.
- Read-first: a read accepted on the cycle after a write to the same address returns the new data. A write cannot share a cycle with a read (single port).
- Reset (async assert, sync release):
  - State = ARB_IDLE, burst_cnt = 0, last_owner = 1, rd_pend = 0.
  - All rvalid = 0; rdata0/rdata1 = 0; ram_addr/ram_wdata registers = 0.
  - A read in flight when reset asserts is dropped; no rvalid follows after release.
- Boundaries:
  - MAX_BURST = 1 gives strict alternation under contention.
  - A requester dropping req mid-burst is legal; the burst ends.
  - burst_cnt saturates and never wraps.

Optional Feature:
- Macro: SP_RAM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention. MAX_BURST, burst_cnt and last_owner are unused (ports unchanged). Requester 1 is granted only when req0 is low.
- Undefined: round-robin with the MAX_BURST fairness limit as specified above.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5, then req0 read addr 3 -> gnt0 on each cycle; rvalid0 = 1 and rdata0 = 0xA5 one cycle after the read is accepted; rvalid1 stays 0.
- req0 and req1 held high with reads from cycle 0, MAX_BURST = 4 -> first grant to 0; grant sequence 0,0,0,0,1,1,1,1,0; never both gnt high.
- req1 writes addr 5 = 0x3C, next cycle req0 reads addr 5 -> rdata0 = 0x3C with rvalid0 one cycle later.
- Continuous read from req1 alone for 10 cycles -> gnt1 every cycle, 10 consecutive rvalid1 pulses, burst limit not applied (no contender).
- Assert rst_n low the cycle after a read is accepted -> rvalid0/1 = 0 immediately, no rvalid after release, state ARB_IDLE, next contention grants requester 0.
- With SP_RAM_ARB_FIXED_PRIO_EN defined, both requesting for 8 cycles -> gnt0 all 8 cycles, gnt1 never; gnt1 asserts on the first cycle req0 drops.
